rxrsp_slc_fifo: RTL and testbench

//  Parametrised successor of the single-entry RXRSP pipe slice. Buffers DEPTH

---
 rtl/rxrsp_slc_fifo.sv | 92 +++++++++
 tb/tb_rxrsp_slc_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rxrsp_slc_fifo.sv
// rxrsp_slc_fifo: DEPTH-entry valid/ready elastic slice for RXRSP response flits with sync flush.
// Optional same-cycle empty bypass is enabled by defining RXRSP_SLC_BYPASS_EN.
module rxrsp_slc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             pin_valid,
  output logic             pin_ready,
  input  logic [WIDTH-1:0] pin_data,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [WIDTH-1:0] pout_data,
  output logic [CNT_W-1:0] occupancy
);

  localparam int               PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == FULL);
  assign pin_ready = ~full & ~flush;
  assign push      = pin_valid & pin_ready;
  assign pop       = pout_valid & pout_ready;
  assign occupancy = count;

`ifdef RXRSP_SLC_BYPASS_EN
  logic bypass;

  // Empty slice with a waiting consumer: the flit flows straight through and storage is untouched.
  assign bypass     = empty & pin_valid & pout_ready & ~flush;
  assign pout_valid = (~empty | pin_valid) & ~flush;
  assign pout_data  = empty ? pin_data : mem[rd_ptr];
  assign wr_en      = push & ~bypass;
  assign rd_en      = pop & ~bypass;
`else
  assign pout_valid = ~empty & ~flush;
  assign pout_data  = mem[rd_ptr];
  assign wr_en      = push;
  assign rd_en      = pop;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives count_nxt; a missing path would infer a latch.
    count_nxt = count;
    case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      count <= count_nxt;
    end
  end

  // NOTE: the data array has no reset; pout_data is only meaningful while pout_valid is high.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= pin_data;
  end

endmodule

// File: tb/tb_rxrsp_slc_fifo.sv
// tb_rxrsp_slc_fifo: queue-model self-checking bench for rxrsp_slc_fifo at DEPTH=2 and DEPTH=3.
// Follows RXRSP_SLC_BYPASS_EN the same way as the design.
module tb_rxrsp_slc_fifo;

`ifdef RXRSP_SLC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rst   = 1'b1;

  logic       fl2 = 1'b0, iv2 = 1'b0, or2 = 1'b0;
  logic [7:0] id2 = '0;
  logic       ir2, ov2;
  logic [7:0] od2;
  logic [1:0] oc2;

  logic       fl3 = 1'b0, iv3 = 1'b0, or3 = 1'b0;
  logic [7:0] id3 = '0;
  logic       ir3, ov3;
  logic [7:0] od3;
  logic [1:0] oc3;

  int         tests = 0;
  int         fails = 0;
  bit         chk_en = 1'b0;

  // Model contents and the flits actually handed downstream, per instance.
  logic [7:0] q2[$], q3[$], log2[$], log3[$];

  always #5 clock = ~clock;

  rxrsp_slc_fifo #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clock(clock), .reset(rst), .flush(fl2),
    .pin_valid(iv2), .pin_ready(ir2), .pin_data(id2),
    .pout_valid(ov2), .pout_ready(or2), .pout_data(od2),
    .occupancy(oc2)
  );

  rxrsp_slc_fifo #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clock(clock), .reset(rst), .flush(fl3),
    .pin_valid(iv3), .pin_ready(ir3), .pin_data(id3),
    .pout_valid(ov3), .pout_ready(or3), .pout_data(od3),
    .occupancy(oc3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a push joins the back, a pop leaves the front; flush or reset empties it.
  always @(posedge clock) begin
    bit p2, o2, p3, o3;
    if (rst || fl2) q2.delete();
    else begin
      p2 = iv2 && (q2.size() != 2);
      o2 = or2 && ((q2.size() != 0) || (BYP && iv2));
      if (p2) q2.push_back(id2);
      if (o2) void'(q2.pop_front());
    end
    if (rst || fl3) q3.delete();
    else begin
      p3 = iv3 && (q3.size() != 3);
      o3 = or3 && ((q3.size() != 0) || (BYP && iv3));
      if (p3) q3.push_back(id3);
      if (o3) void'(q3.pop_front());
    end
  end

  // Per-cycle comparison against the model, midway between active edges.
  always @(negedge clock) begin
    bit ev2, ev3;
    if (chk_en) begin
      ev2 = ((q2.size() != 0) || (BYP && iv2)) && !fl2;
      check("d2_ready", 32'(ir2), 32'((q2.size() != 2) && !fl2));
      check("d2_valid", 32'(ov2), 32'(ev2));
      check("d2_occ", 32'(oc2), 32'(q2.size()));
      if (ev2) check("d2_data", 32'(od2), 32'((q2.size() != 0) ? q2[0] : id2));
      if (ov2 && or2) log2.push_back(od2);

      ev3 = ((q3.size() != 0) || (BYP && iv3)) && !fl3;
      check("d3_ready", 32'(ir3), 32'((q3.size() != 3) && !fl3));
      check("d3_valid", 32'(ov3), 32'(ev3));
      check("d3_occ", 32'(oc3), 32'(q3.size()));
      if (ev3) check("d3_data", 32'(od3), 32'((q3.size() != 0) ? q3[0] : id3));
      if (ov3 && or3) log3.push_back(od3);
    end
  end

  task automatic cyc2(input logic v, input logic [7:0] d, input logic r, input logic f);
    iv2 = v; id2 = d; or2 = r; fl2 = f;
    @(posedge clock); #1;
  endtask

  task automatic cyc3(input logic v, input logic [7:0] d, input logic r, input logic f);
    iv3 = v; id3 = d; or3 = r; fl3 = f;
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    check("rst_valid", 32'(ov2), 32'h0);
    check("rst_occ", 32'(oc2), 32'h0);
    check("rst_ready", 32'(ir2), 32'h1);
    check("rst_occ3", 32'(oc3), 32'h0);

    // Fill DEPTH=2, third flit held upstream, then drain in order.
    cyc2(1'b1, 8'hA1, 1'b0, 1'b0);
    cyc2(1'b1, 8'hA2, 1'b0, 1'b0);
    cyc2(1'b1, 8'hA3, 1'b0, 1'b0);
    check("full_occ", 32'(oc2), 32'h2);
    check("full_ready", 32'(ir2), 32'h0);
    check("full_head", 32'(od2), 32'hA1);
    // Full with pop and push offered: pop only.
    cyc2(1'b1, 8'hA3, 1'b1, 1'b0);
    check("popfull_occ", 32'(oc2), 32'h1);
    check("popfull_ready", 32'(ir2), 32'h1);
    cyc2(1'b1, 8'hA3, 1'b1, 1'b0);
    check("after_push_occ", 32'(oc2), 32'h1);
    check("after_push_head", 32'(od2), 32'hA3);
    cyc2(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained_occ", 32'(oc2), 32'h0);
    check("order_count", 32'(log2.size()), 32'd3);
    if (log2.size() == 3) begin
      check("order_0", 32'(log2[0]), 32'hA1);
      check("order_1", 32'(log2[1]), 32'hA2);
      check("order_2", 32'(log2[2]), 32'hA3);
    end

    // Flush with two entries held and a flit offered.
    cyc2(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc2(1'b1, 8'hB2, 1'b0, 1'b0);
    iv2 = 1'b1; id2 = 8'hB3; or2 = 1'b1; fl2 = 1'b1;
    #1;
    check("flush_ready", 32'(ir2), 32'h0);
    check("flush_valid", 32'(ov2), 32'h0);
    @(posedge clock); #1;
    iv2 = 1'b0; fl2 = 1'b0;
    #1;
    check("post_flush_occ", 32'(oc2), 32'h0);
    check("post_flush_valid", 32'(ov2), 32'h0);
    cyc2(1'b0, 8'h00, 1'b1, 1'b0);
    check("flush_no_leak", 32'(log2.size()), 32'd3);

    // Empty slice, flit offered with consumer ready.
    iv2 = 1'b1; id2 = 8'h5C; or2 = 1'b1;
    #1;
    check("byp_valid", 32'(ov2), 32'(BYP));
`ifdef RXRSP_SLC_BYPASS_EN
    check("byp_data", 32'(od2), 32'h5C);
`endif
    @(posedge clock); #1;
    iv2 = 1'b0;
    #1;
    check("byp_occ", 32'(oc2), BYP ? 32'h0 : 32'h1);
    check("byp_next_valid", 32'(ov2), BYP ? 32'h0 : 32'h1);
`ifndef RXRSP_SLC_BYPASS_EN
    check("nobyp_next_data", 32'(od2), 32'h5C);
`endif
    @(posedge clock); #1;
    check("byp_final_occ", 32'(oc2), 32'h0);
    check("byp_log_last", 32'(log2[log2.size()-1]), 32'h5C);

    // DEPTH=3 streaming: pointers wrap, one flit per cycle.
    for (int i = 0; i < 10; i++) begin
      cyc3(1'b1, 8'(i), 1'b1, 1'b0);
      check("stream_occ", 32'(oc3), BYP ? 32'h0 : 32'h1);
    end
    cyc3(1'b0, 8'h00, 1'b1, 1'b0);
    cyc3(1'b0, 8'h00, 1'b0, 1'b0);
    check("stream_count", 32'(log3.size()), 32'd10);
    if (log3.size() == 10)
      for (int i = 0; i < 10; i++) check("stream_order", 32'(log3[i]), 32'(i));

    // Randomised traffic, both depths, occasional flush.
    repeat (3000) begin
      iv2 = ($urandom_range(0, 3) != 0);
      id2 = 8'($urandom);
      or2 = ($urandom_range(0, 2) != 0);
      fl2 = ($urandom_range(0, 40) == 0);
      iv3 = ($urandom_range(0, 2) != 0);
      id3 = 8'($urandom);
      or3 = ($urandom_range(0, 2) == 0);
      fl3 = ($urandom_range(0, 60) == 0);
      @(posedge clock); #1;
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
